// File: rtl/cpu_pkg.sv
// Shared CPU pipeline types: MDU sequencer state encoding and timing defaults.
// Pure declarations; no latency and no flow control.
package cpu_pkg;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_BUSY = 2'd1,
        MDU_DONE = 2'd2
    } mdu_state_t;

    localparam int MDU_LATENCY_DEF = 4;
    localparam int MDU_CNT_W       = 5;

    typedef struct packed {
        logic pc_wr_en;
        logic if_id_wr_en;
        logic id_ex_wr_en;
        logic if_id_flush;
        logic id_ex_flush;
        logic ex_mem_bubble;
    } hz_ctrl_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard-unit bundle: pipeline hazard sources in, write enables / flushes / MDU status out.
// Wires only; slave is the hazard unit, master is the pipeline side driving it.
interface hazard_ctrl_if #(parameter int CNT_W = 16);
    logic [4:0]       ID_rs;
    logic [4:0]       ID_rt;
    logic             ID_uses_rt;
    logic             ID_jump;
    logic             ID_EX_mem_rd;
    logic [4:0]       ID_EX_rt;
    logic             EX_branch_taken;
    logic             EX_mdu_start;
    logic             PC_wr_en;
    logic             IF_ID_wr_en;
    logic             ID_EX_wr_en;
    logic             IF_ID_flush;
    logic             ID_EX_flush;
    logic             EX_MEM_bubble;
    logic             mdu_busy;
    logic             mdu_done;
    logic [CNT_W-1:0] stall_cycles;

    modport slave (
        input  ID_rs, ID_rt, ID_uses_rt, ID_jump, ID_EX_mem_rd, ID_EX_rt,
               EX_branch_taken, EX_mdu_start,
        output PC_wr_en, IF_ID_wr_en, ID_EX_wr_en, IF_ID_flush, ID_EX_flush,
               EX_MEM_bubble, mdu_busy, mdu_done, stall_cycles
    );

    modport master (
        output ID_rs, ID_rt, ID_uses_rt, ID_jump, ID_EX_mem_rd, ID_EX_rt,
               EX_branch_taken, EX_mdu_start,
        input  PC_wr_en, IF_ID_wr_en, ID_EX_wr_en, IF_ID_flush, ID_EX_flush,
               EX_MEM_bubble, mdu_busy, mdu_done, stall_cycles
    );
endinterface

// File: rtl/mdu_seq.sv
// Multiply/divide sequencer: IDLE->BUSY->DONE, stall asserted for MDU_LATENCY cycles from start.
// Stall/done are combinational from state and start; start is ignored outside IDLE.
module mdu_seq
    import cpu_pkg::*;
#(
    parameter int MDU_LATENCY = MDU_LATENCY_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_start,
    output logic o_stall,
    output logic o_done
);

    localparam logic [MDU_CNT_W-1:0] LP_LOAD = MDU_CNT_W'(MDU_LATENCY - 1);

    mdu_state_t           r_state;
    mdu_state_t           w_next;
    logic [MDU_CNT_W-1:0] r_cnt;
    logic [MDU_CNT_W-1:0] w_cnt_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= MDU_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // The start cycle itself counts as the first stall, hence the load of LATENCY-1.
    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        case (r_state)
            MDU_IDLE: begin
                if (i_start) begin
                    w_next     = MDU_BUSY;
                    w_cnt_next = LP_LOAD;
                end
            end
            MDU_BUSY: begin
                w_cnt_next = r_cnt - MDU_CNT_W'(1);
                if (r_cnt == MDU_CNT_W'(1)) begin
                    w_next = MDU_DONE;
                end
            end
            MDU_DONE: w_next = MDU_IDLE;
            default:  w_next = MDU_IDLE;
        endcase
    end

    always_comb begin
        o_stall = rst_n && (((r_state == MDU_IDLE) && i_start) || (r_state == MDU_BUSY));
        o_done  = rst_n && (r_state == MDU_DONE);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: MDU stall > taken branch > load-use > jump, zero-cycle combinational outputs.
// Stalls by dropping write enables; flushes/bubbles insert NOPs; counts stalled cycles (saturating).
module hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int MDU_LATENCY = MDU_LATENCY_DEF,
    parameter int CNT_W       = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    hazard_ctrl_if.slave  bus
);

    logic             w_mdu_stall;
    logic             w_mdu_done;
    logic             w_load_use;
    hz_ctrl_t         w_ctl;
    logic [CNT_W-1:0] r_stall_cycles;

    mdu_seq #(
        .MDU_LATENCY (MDU_LATENCY)
    ) u_mdu_seq (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (bus.EX_mdu_start),
        .o_stall (w_mdu_stall),
        .o_done  (w_mdu_done)
    );

    assign w_load_use = bus.ID_EX_mem_rd && (bus.ID_EX_rt != 5'd0) &&
                        ((bus.ID_EX_rt == bus.ID_rs) ||
                         (bus.ID_uses_rt && (bus.ID_EX_rt == bus.ID_rt)));

    // Lower-priority events are simply dropped; the held ID instruction re-raises them.
    always_comb begin
        w_ctl = '{pc_wr_en: 1'b1, if_id_wr_en: 1'b1, id_ex_wr_en: 1'b1,
                  if_id_flush: 1'b0, id_ex_flush: 1'b0, ex_mem_bubble: 1'b0};
        if (!rst_n) begin
            w_ctl = '{pc_wr_en: 1'b0, if_id_wr_en: 1'b0, id_ex_wr_en: 1'b0,
                      if_id_flush: 1'b1, id_ex_flush: 1'b1, ex_mem_bubble: 1'b0};
        end else if (w_mdu_stall) begin
            w_ctl.pc_wr_en      = 1'b0;
            w_ctl.if_id_wr_en   = 1'b0;
            w_ctl.id_ex_wr_en   = 1'b0;
            w_ctl.ex_mem_bubble = 1'b1;
        end else if (bus.EX_branch_taken) begin
            w_ctl.if_id_flush = 1'b1;
            w_ctl.id_ex_flush = 1'b1;
        end else if (w_load_use) begin
            w_ctl.pc_wr_en    = 1'b0;
            w_ctl.if_id_wr_en = 1'b0;
            w_ctl.id_ex_flush = 1'b1;
        end else if (bus.ID_jump) begin
            w_ctl.if_id_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cycles <= '0;
        end else if (!w_ctl.pc_wr_en && (r_stall_cycles != '1)) begin
            r_stall_cycles <= r_stall_cycles + CNT_W'(1);
        end
    end

    assign bus.PC_wr_en      = w_ctl.pc_wr_en;
    assign bus.IF_ID_wr_en   = w_ctl.if_id_wr_en;
    assign bus.ID_EX_wr_en   = w_ctl.id_ex_wr_en;
    assign bus.IF_ID_flush   = w_ctl.if_id_flush;
    assign bus.ID_EX_flush   = w_ctl.id_ex_flush;
    assign bus.EX_MEM_bubble = w_ctl.ex_mem_bubble;
    assign bus.mdu_busy      = w_mdu_stall;
    assign bus.mdu_done      = w_mdu_done;
    assign bus.stall_cycles  = r_stall_cycles;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table plus MDU, reset, jump and saturation sequences.
module tb_hazard_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hazard_ctrl_if #(.CNT_W(16)) hif ();
    hazard_ctrl_if #(.CNT_W(4))  sif ();

    hazard_ctrl #(.MDU_LATENCY(4), .CNT_W(16)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (hif)
    );

    hazard_ctrl #(.MDU_LATENCY(4), .CNT_W(4)) u_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sif)
    );

    // exp packs {PC, IF_ID_wr, ID_EX_wr, IF_ID_flush, ID_EX_flush, EX_MEM_bubble, busy, done}
    typedef struct {
        string      name;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic       jump;
        logic       mem_rd;
        logic [4:0] ex_rt;
        logic       br;
        logic       mdu;
        logic [7:0] exp;
    } vec_t;

    typedef struct {
        string      name;
        logic [7:0] o;
    } exp_t;

    localparam logic [7:0] E_IDLE  = 8'b111_00_0_00;
    localparam logic [7:0] E_LU    = 8'b001_01_0_00;
    localparam logic [7:0] E_BR    = 8'b111_11_0_00;
    localparam logic [7:0] E_JMP   = 8'b111_10_0_00;
    localparam logic [7:0] E_MDU   = 8'b000_00_1_10;
    localparam logic [7:0] E_DONE  = 8'b111_00_0_01;
    localparam logic [7:0] E_RST   = 8'b000_11_0_00;

    exp_t sb[$];
    vec_t tbl[11];
    int   total = 0;
    int   bad   = 0;
    int   exp_cnt = 0;

    function automatic vec_t mk(string n, logic [4:0] rs, logic [4:0] rt, logic u, logic j,
                                logic m, logic [4:0] xr, logic b, logic d, logic [7:0] e);
        vec_t v;
        v.name = n; v.rs = rs; v.rt = rt; v.uses_rt = u; v.jump = j;
        v.mem_rd = m; v.ex_rt = xr; v.br = b; v.mdu = d; v.exp = e;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        hif.ID_rs           = v.rs;
        hif.ID_rt           = v.rt;
        hif.ID_uses_rt      = v.uses_rt;
        hif.ID_jump         = v.jump;
        hif.ID_EX_mem_rd    = v.mem_rd;
        hif.ID_EX_rt        = v.ex_rt;
        hif.EX_branch_taken = v.br;
        hif.EX_mdu_start    = v.mdu;
        sb.push_back('{v.name, v.exp});
    endtask

    task automatic sample();
        exp_t       e;
        logic [7:0] act;
        @(negedge clk);
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL scoreboard: no expectation queued at t=%0t", $time);
        end else begin
            e   = sb.pop_front();
            act = {hif.PC_wr_en, hif.IF_ID_wr_en, hif.ID_EX_wr_en, hif.IF_ID_flush,
                   hif.ID_EX_flush, hif.EX_MEM_bubble, hif.mdu_busy, hif.mdu_done};
            if (act !== e.o) begin
                bad++;
                $display("FAIL %s ctrl: got %b want %b", e.name, act, e.o);
            end
            total++;
            if (hif.stall_cycles !== 16'(exp_cnt)) begin
                bad++;
                $display("FAIL %s stall_cycles: got %0d want %0d", e.name, hif.stall_cycles, exp_cnt);
            end
            if (rst_n && !e.o[7] && exp_cnt < 65535) exp_cnt++;
        end
    endtask

    task automatic step(input vec_t v);
        @(posedge clk);
        #1;
        drive(v);
        sample();
    endtask

    task automatic check_val(input string n, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", n, act, want);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        sif.ID_rs = '0; sif.ID_rt = '0; sif.ID_uses_rt = 1'b0; sif.ID_jump = 1'b0;
        sif.ID_EX_mem_rd = 1'b0; sif.ID_EX_rt = '0; sif.EX_branch_taken = 1'b0;
        sif.EX_mdu_start = 1'b0;

        tbl[0]  = mk("idle",          5'd1, 5'd2, 1, 0, 0, 5'd0, 0, 0, E_IDLE);
        tbl[1]  = mk("lu_rs",         5'd8, 5'd0, 0, 0, 1, 5'd8, 0, 0, E_LU);
        tbl[2]  = mk("lu_rt_zero",    5'd0, 5'd0, 1, 0, 1, 5'd0, 0, 0, E_IDLE);
        tbl[3]  = mk("lu_rt_unused",  5'd3, 5'd9, 0, 0, 1, 5'd9, 0, 0, E_IDLE);
        tbl[4]  = mk("lu_rt_used",    5'd3, 5'd9, 1, 0, 1, 5'd9, 0, 0, E_LU);
        tbl[5]  = mk("no_load",       5'd8, 5'd0, 0, 0, 0, 5'd8, 0, 0, E_IDLE);
        tbl[6]  = mk("branch",        5'd1, 5'd2, 0, 0, 0, 5'd0, 1, 0, E_BR);
        tbl[7]  = mk("branch_lu",     5'd8, 5'd0, 0, 0, 1, 5'd8, 1, 0, E_BR);
        tbl[8]  = mk("jump",          5'd1, 5'd2, 0, 1, 0, 5'd0, 0, 0, E_JMP);
        tbl[9]  = mk("branch_jump",   5'd1, 5'd2, 0, 1, 0, 5'd0, 1, 0, E_BR);
        tbl[10] = mk("jump_lu_miss",  5'd4, 5'd2, 0, 1, 1, 5'd8, 0, 0, E_JMP);

        // Reset state, with a start request present that must not show as busy.
        drive(mk("reset", 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, E_RST));
        sample();
        hif.EX_mdu_start = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;

        foreach (tbl[i]) step(tbl[i]);

        // MDU run with a coincident branch at start, noise in BUSY and a start in DONE.
        step(mk("mdu_c0_br",   5'd1, 5'd2, 0, 0, 0, 5'd0, 1, 1, E_MDU));
        step(mk("mdu_c1_lu",   5'd8, 5'd0, 0, 0, 1, 5'd8, 0, 0, E_MDU));
        step(mk("mdu_c2",      5'd1, 5'd2, 0, 1, 0, 5'd0, 0, 0, E_MDU));
        step(mk("mdu_c3_st",   5'd1, 5'd2, 0, 0, 0, 5'd0, 0, 1, E_MDU));
        step(mk("mdu_c4_done", 5'd1, 5'd2, 0, 0, 0, 5'd0, 0, 1, E_DONE));
        step(mk("mdu_c5_idle", 5'd1, 5'd2, 0, 0, 0, 5'd0, 0, 0, E_IDLE));

        // Jump coincident with load-use: stall first, then the jump flush.
        step(mk("jlu_stall",   5'd5, 5'd2, 0, 1, 1, 5'd5, 0, 0, E_LU));
        step(mk("jlu_flush",   5'd5, 5'd2, 0, 1, 0, 5'd5, 0, 0, E_JMP));

        // Asynchronous reset in the second BUSY cycle.
        step(mk("rb_c0", 5'd1, 5'd2, 0, 0, 0, 5'd0, 0, 1, E_MDU));
        step(mk("rb_c1", 5'd1, 5'd2, 0, 0, 0, 5'd0, 0, 0, E_MDU));
        @(posedge clk);
        #1;
        drive(mk("rb_c2_rst", 5'd1, 5'd2, 0, 0, 0, 5'd0, 0, 0, E_RST));
        #1;
        rst_n   = 1'b0;
        exp_cnt = 0;
        sample();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(mk("rb_release", 5'd1, 5'd2, 0, 0, 0, 5'd0, 0, 0, E_IDLE));
        sample();
        step(mk("rb_idle", 5'd1, 5'd2, 0, 0, 0, 5'd0, 0, 0, E_IDLE));

        // Saturation on a 4-bit counter under a held load-use stall.
        for (int i = 0; i < 22; i++) begin
            @(posedge clk);
            #1;
            sif.ID_rs = 5'd8; sif.ID_EX_rt = 5'd8; sif.ID_EX_mem_rd = 1'b1;
            @(negedge clk);
            check_val($sformatf("sat_cyc%0d", i), int'(sif.stall_cycles), (i < 15) ? i : 15);
        end
        check_val("sat_pc_low", int'(sif.PC_wr_en), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
